// File: rtl/tile_line_renderer_pkg.sv
// rtl/tile_line_renderer_pkg.sv - shared codes, FSM encoding and tile size for the line renderer
package tile_line_renderer_pkg;

  localparam int TILE = 8;

  localparam logic [1:0] WR_TMAP = 2'd0;
  localparam logic [1:0] WR_PAT  = 2'd1;
  localparam logic [1:0] WR_PAL  = 2'd2;
  localparam logic [1:0] WR_CLR  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_TMAP = 2'd1,
    S_PAT  = 2'd2,
    S_EMIT = 2'd3
  } state_t;

endpackage

// File: rtl/tile_line_renderer_if.sv
// rtl/tile_line_renderer_if.sv - LCD-side and CPU write-port signals of the line renderer
interface tile_line_renderer_if #(
  parameter int WIDTH = 160
);
  logic                     hsync;
  logic                     vsync;
  logic [$clog2(WIDTH)-1:0] hpos;
  logic                     wr_en;
  logic [1:0]               wr_sel;
  logic [9:0]               wr_addr;
  logic [15:0]              wr_data;
  logic [4:0]               red;
  logic [5:0]               green;
  logic [4:0]               blue;
  logic                     busy;
  logic                     overrun;

  modport master (
    output hsync, vsync, hpos, wr_en, wr_sel, wr_addr, wr_data,
    input  red, green, blue, busy, overrun
  );

  modport slave (
    input  hsync, vsync, hpos, wr_en, wr_sel, wr_addr, wr_data,
    output red, green, blue, busy, overrun
  );
endinterface

// File: rtl/tile_line_renderer_sync_edge.sv
// rtl/tile_line_renderer_sync_edge.sv - 2-flop synchroniser with registered rising-edge pulse
module sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic pulse
);
  logic s1, s2, s3;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      s3    <= 1'b0;
      pulse <= 1'b0;
    end else begin
      s1    <= d;
      s2    <= s1;
      s3    <= s2;
      pulse <= s2 & ~s3;
    end
  end
endmodule

// File: rtl/tile_line_renderer.sv
// rtl/tile_line_renderer.sv - renders a tile-mapped scanline one line ahead into a double-buffered line buffer
module tile_line_renderer
  import tile_line_renderer_pkg::*;
#(
  parameter int WIDTH  = 160,
  parameter int HEIGHT = 120,
  parameter int TILES  = 64
) (
  input logic                 clk,
  input logic                 reset,
  tile_line_renderer_if.slave bus
);
  localparam int COLS    = WIDTH / TILE;
  localparam int TMAP_N  = COLS * (HEIGHT / TILE);
  localparam int PAT_N   = TILES * TILE;
  localparam int TMAP_AW = $clog2(TMAP_N);
  localparam int PAT_AW  = $clog2(PAT_N);
  localparam int LB_AW   = $clog2(WIDTH);
  localparam int COL_W   = $clog2(COLS);
  localparam int LINE_W  = $clog2(HEIGHT);
  localparam int PIX_W   = $clog2(TILE);

  logic                h_pulse, v_pulse, start, busy, lb_we, clr_wr;
  state_t              state, state_n;
  logic                disp_buf, rbuf, overrun;
  logic [LINE_W-1:0]   line_q, next_line;
  logic [COL_W-1:0]    col_q;
  logic [PIX_W-1:0]    pix_q;
  logic [5:0]          tile_q;
  logic [15:0]         pat_q, colour, colour_q;
  logic [TMAP_AW-1:0]  tmap_ra;
  logic [PAT_AW-1:0]   pat_ra;
  logic [LB_AW-1:0]    lb_wa;

  logic [5:0]          tmap_mem [TMAP_N];
  logic [15:0]         pat_mem  [PAT_N];
  logic [15:0]         pal_mem  [4];
  logic [1:0]          linebuf  [2][WIDTH];

  sync_edge u_hsync (.clk(clk), .reset(reset), .d(bus.hsync), .pulse(h_pulse));
  sync_edge u_vsync (.clk(clk), .reset(reset), .d(bus.vsync), .pulse(v_pulse));

  assign start   = h_pulse | v_pulse;
  assign busy    = (state != S_IDLE);
  assign clr_wr  = bus.wr_en && (bus.wr_sel == WR_CLR);
  assign tmap_ra = TMAP_AW'((int'(line_q) / TILE) * COLS + int'(col_q));
  assign pat_ra  = PAT_AW'(int'(tile_q) * TILE + int'(line_q) % TILE);
  assign lb_wa   = LB_AW'(int'(col_q) * TILE + int'(pix_q));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_n;
  end

  // A start pulse always restarts at TMAP, aborting any render in progress.
  always_comb begin
    state_n = state;
    lb_we   = 1'b0;
    if (start) begin
      state_n = S_TMAP;
    end else begin
      case (state)
        S_TMAP: state_n = S_PAT;
        S_PAT:  state_n = S_EMIT;
        S_EMIT: begin
          lb_we = 1'b1;
          if (pix_q == PIX_W'(TILE - 1))
            state_n = (col_q == COL_W'(COLS - 1)) ? S_IDLE : S_TMAP;
        end
        default: state_n = state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      disp_buf  <= 1'b0;
      rbuf      <= 1'b0;
      line_q    <= '0;
      next_line <= '0;
      col_q     <= '0;
      pix_q     <= '0;
      overrun   <= 1'b0;
    end else begin
      if (v_pulse) begin
        disp_buf  <= 1'b0;
        rbuf      <= 1'b0;
        line_q    <= '0;
        next_line <= LINE_W'(1);
      end else if (h_pulse) begin
        disp_buf  <= ~disp_buf;
        rbuf      <= disp_buf;
        line_q    <= next_line;
        next_line <= (next_line == LINE_W'(HEIGHT - 1)) ? '0 : next_line + 1'b1;
      end
      if (start) begin
        col_q <= '0;
        pix_q <= '0;
      end else if (state == S_EMIT) begin
        pix_q <= pix_q + 1'b1;
        if (pix_q == PIX_W'(TILE - 1))
          col_q <= (col_q == COL_W'(COLS - 1)) ? '0 : col_q + 1'b1;
      end
      // Setting wins over both the CPU clear and the frame-start clear.
      if (start && busy)          overrun <= 1'b1;
      else if (v_pulse || clr_wr) overrun <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (bus.wr_en) begin
      case (bus.wr_sel)
        WR_TMAP: if (int'(bus.wr_addr) < TMAP_N) tmap_mem[TMAP_AW'(bus.wr_addr)] <= bus.wr_data[5:0];
        WR_PAT:  if (int'(bus.wr_addr) < PAT_N)  pat_mem[PAT_AW'(bus.wr_addr)]   <= bus.wr_data;
        WR_PAL:  if (int'(bus.wr_addr) < 4)      pal_mem[2'(bus.wr_addr)]        <= bus.wr_data;
        default: ;
      endcase
    end
    if (state == S_TMAP) tile_q <= tmap_mem[tmap_ra];
    if (state == S_PAT)
      pat_q <= (int'(tile_q) < TILES) ? pat_mem[pat_ra] : '0;
    else if (state == S_EMIT)
      pat_q <= {pat_q[13:0], 2'b00};
    if (lb_we) linebuf[rbuf][lb_wa] <= pat_q[15:14];
  end

  always_comb begin
    colour = pal_mem[0];
    if (int'(bus.hpos) < WIDTH) colour = pal_mem[linebuf[disp_buf][bus.hpos]];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) colour_q <= '0;
    else        colour_q <= colour;
  end

  assign bus.red     = colour_q[15:11];
  assign bus.green   = colour_q[10:5];
  assign bus.blue    = colour_q[4:0];
  assign bus.busy    = busy;
  assign bus.overrun = overrun;

endmodule

// File: tb/tb_tile_line_renderer.sv
// tb/tb_tile_line_renderer.sv - directed self-checking bench for tile_line_renderer
module tb_tile_line_renderer;
  import tile_line_renderer_pkg::*;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   n_chk  = 0;
  int   n_pass = 0;
  int   lat, len, cnt, bad;
  logic [15:0] c;
  logic [15:0] exp_l0   [4] = '{16'h0000, 16'hF800, 16'h07E0, 16'h001F};
  logic [15:0] exp_l119 [4] = '{16'h001F, 16'h07E0, 16'hF800, 16'h0000};

  always #5 clk = ~clk;

  tile_line_renderer_if #(.WIDTH(160)) bus ();

  tile_line_renderer #(.WIDTH(160), .HEIGHT(120), .TILES(64)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic cpu_wr(input logic [1:0] sel, input int addr, input logic [15:0] data);
    @(negedge clk);
    bus.wr_en   = 1'b1;
    bus.wr_sel  = sel;
    bus.wr_addr = 10'(addr);
    bus.wr_data = data;
    @(negedge clk);
    bus.wr_en   = 1'b0;
  endtask

  task automatic colour_at(input int h, output logic [15:0] col);
    @(negedge clk);
    bus.hpos = 8'(h);
    @(negedge clk);
    @(negedge clk);
    col = {bus.red, bus.green, bus.blue};
  endtask

  // Raises the sync level(s), measures edges until busy and how long busy stays high.
  task automatic line_pulse(input logic h, input logic v, output int lat_o, output int len_o);
    @(negedge clk);
    bus.hsync = h;
    bus.vsync = v;
    lat_o = 0;
    do begin
      @(posedge clk); #1;
      lat_o++;
    end while (!bus.busy && lat_o < 20);
    len_o = bus.busy ? 1 : 0;
    while (bus.busy && len_o < 1000) begin
      @(posedge clk); #1;
      if (bus.busy) len_o++;
      if (len_o == 6) begin
        bus.hsync = 1'b0;
        bus.vsync = 1'b0;
      end
    end
    bus.hsync = 1'b0;
    bus.vsync = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    bus.hsync = 0; bus.vsync = 0; bus.hpos = 0;
    bus.wr_en = 0; bus.wr_sel = 0; bus.wr_addr = 0; bus.wr_data = 0;

    repeat (3) @(posedge clk); #1;
    check("rst_rgb", {bus.red, bus.green, bus.blue}, 16'h0000);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_overrun", bus.overrun, 1'b0);
    @(negedge clk) reset = 1'b1;
    repeat (5) @(posedge clk); #1;
    check("idle_busy", bus.busy, 1'b0);

    for (int i = 0; i < 4; i++) cpu_wr(WR_PAL, i, exp_l0[i]);
    cpu_wr(WR_PAL, 4, 16'hFFFF);
    for (int a = 0; a < 300; a++) cpu_wr(WR_TMAP, a, (a == 0) ? 16'd1 : (a == 280) ? 16'd2 : 16'd0);
    for (int a = 0; a < 512; a++)
      cpu_wr(WR_PAT, a, (a >= 8 && a < 16) ? 16'h1B1B : (a == 23) ? 16'hE4E4 : 16'h0000);

    line_pulse(1'b0, 1'b1, lat, len);
    check("v_latency", lat, 4);
    check("v_busy_len", len, 200);
    for (int h = 0; h < 4; h++) begin
      colour_at(h, c);
      check($sformatf("l0_hpos%0d", h), c, exp_l0[h]);
    end
    colour_at(8, c);
    check("l0_hpos8", c, 16'h0000);
    colour_at(200, c);
    check("hpos_oob", c, 16'h0000);

    line_pulse(1'b1, 1'b0, lat, len);
    check("h_latency", lat, 4);
    check("h_busy_len", len, 200);
    line_pulse(1'b1, 1'b0, lat, len);
    colour_at(1, c);
    check("l1_hpos1", c, 16'hF800);
    colour_at(3, c);
    check("l1_hpos3", c, 16'h001F);

    @(negedge clk);
    bus.hsync = 1'b1;
    cnt = 0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      if (bus.busy) cnt++;
      if (i == 9)  bus.hsync = 1'b0;
      if (i == 49) bus.hsync = 1'b1;
      if (i == 59) bus.hsync = 1'b0;
    end
    check("ovr_busy_len", cnt, 250);
    check("ovr_set", bus.overrun, 1'b1);
    cpu_wr(WR_CLR, 0, 16'h0000);
    @(posedge clk); #1;
    check("ovr_clear", bus.overrun, 1'b0);

    colour_at(1, c);
    @(negedge clk);
    bus.hsync = 1'b1;
    repeat (10) @(posedge clk); #1;
    bus.hsync = 1'b0;
    repeat (10) @(posedge clk); #1;
    bus.hsync = 1'b1;
    repeat (8) @(posedge clk); #1;
    check("pre_rst_busy", bus.busy, 1'b1);
    check("pre_rst_overrun", bus.overrun, 1'b1);
    check("pre_rst_rgb", {bus.red, bus.green, bus.blue}, 16'hF800);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_rgb", {bus.red, bus.green, bus.blue}, 16'h0000);
    check("mid_rst_busy", bus.busy, 1'b0);
    check("mid_rst_overrun", bus.overrun, 1'b0);
    @(negedge clk) bus.hsync = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (30) @(posedge clk); #1;
    check("post_rst_idle", bus.busy, 1'b0);
    check("post_rst_rgb", {bus.red, bus.green, bus.blue}, 16'hF800);

    line_pulse(1'b0, 1'b1, lat, len);
    bad = 0;
    for (int k = 1; k <= 120; k++) begin
      line_pulse(1'b1, 1'b0, lat, len);
      if (lat != 4 || len != 200) bad++;
    end
    check("wrap_busy_bad", bad, 0);
    for (int h = 0; h < 4; h++) begin
      colour_at(h, c);
      check($sformatf("l119_hpos%0d", h), c, exp_l119[h]);
    end
    colour_at(8, c);
    check("l119_hpos8", c, 16'h0000);
    line_pulse(1'b1, 1'b0, lat, len);
    colour_at(1, c);
    check("wrap_l0_hpos1", c, 16'hF800);
    colour_at(3, c);
    check("wrap_l0_hpos3", c, 16'h001F);

    line_pulse(1'b1, 1'b1, lat, len);
    check("vh_latency", lat, 4);
    check("vh_busy_len", len, 200);
    check("vh_overrun", bus.overrun, 1'b0);
    colour_at(2, c);
    check("vh_hpos2", c, 16'h07E0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
